// File: rtl/branch_comp_pkg.sv
// branch_comp_pkg: shared width default and br_un encodings for the branch comparator
package branch_comp_pkg;
    localparam int XLEN = 32;
    localparam logic BR_SIGNED = 1'b0;
    localparam logic BR_UNSIGNED = 1'b1;
endpackage

// File: rtl/branch_mag_cmp.sv
// branch_mag_cmp: one extended subtraction yields both equality and less-than
module branch_mag_cmp
    import branch_comp_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             br_un,
    output logic             eq,
    output logic             lt
);
    logic [WIDTH:0] diff;
    // the extra bit absorbs overflow, so its value is the true sign of a-b
    always_comb begin
        diff = {(br_un == BR_SIGNED) & a[WIDTH-1], a} - {(br_un == BR_SIGNED) & b[WIDTH-1], b};
        eq = diff == '0;
        lt = diff[WIDTH];
    end
endmodule

// File: rtl/branch_comp.sv
// branch_comp: execute-stage branch comparator with optional output register
module branch_comp
    import branch_comp_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             br_un,
    output logic             br_eq,
    output logic             br_lt
);
    logic eq;
    logic lt;
    branch_mag_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a(a),
        .b(b),
        .br_un(br_un),
        .eq(eq),
        .lt(lt)
    );
    if (REG_OUT != 0) begin : g_reg
        // register the flags; reset clears them at once and discards anything pending
        always_ff @(posedge clk or posedge rst) begin
            if (rst) {br_eq, br_lt} <= 2'b00;
            else {br_eq, br_lt} <= {eq, lt};
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign br_eq = eq;
        assign br_lt = lt;
    end
endmodule

// File: tb/tb_branch_comp.sv
// tb_branch_comp: scoreboard bench for combinational and registered branch_comp builds
module tb_branch_comp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic br_un = 1'b0;
    logic c_eq, c_lt, r_eq, r_lt;
    logic [1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic un;
        logic eq;
        logic lt;
    } vec_t;

    vec_t dir[18] = '{
        {32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0},
        {32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1},
        {32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0},
        {32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0},
        {32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0},
        {32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0},
        {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0},
        {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0},
        {32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1},
        {32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0},
        {32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b0},
        {32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b1},
        {32'h00000005, 32'h00000009, 1'b0, 1'b0, 1'b1},
        {32'h00000005, 32'h00000009, 1'b1, 1'b0, 1'b1},
        {32'h00000009, 32'h00000005, 1'b0, 1'b0, 1'b0},
        {32'h00000009, 32'h00000005, 1'b1, 1'b0, 1'b0},
        {32'h80000005, 32'h00000005, 1'b0, 1'b0, 1'b1},
        {32'h80000005, 32'h00000005, 1'b1, 1'b0, 1'b0}
    };

    branch_comp #(.WIDTH(32), .REG_OUT(0)) dut_c (
        .clk(clk), .rst(rst), .a(a), .b(b), .br_un(br_un), .br_eq(c_eq), .br_lt(c_lt)
    );
    branch_comp #(.WIDTH(32), .REG_OUT(1)) dut_r (
        .clk(clk), .rst(rst), .a(a), .b(b), .br_un(br_un), .br_eq(r_eq), .br_lt(r_lt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] golden(input logic [31:0] x, input logic [31:0] y, input logic un);
        logic lt;
        lt = un ? ($unsigned(x) < $unsigned(y)) : ($signed(x) < $signed(y));
        return {x == y, lt};
    endfunction

    task automatic test_reset();
        logic [1:0] got;
        rst = 1'b1;
        #1;
        got = {r_eq, r_lt};
        n_cmp++;
        if (got !== 2'b00) begin
            n_err++;
            $display("FAIL reset_state got=%b want=00", got);
        end
    endtask

    task automatic test_directed();
        logic [1:0] got, want;
        for (int i = 0; i < 18; i++) begin
            a = dir[i].a;
            b = dir[i].b;
            br_un = dir[i].un;
            exp_q.push_back({dir[i].eq, dir[i].lt});
            #1;
            got = {c_eq, c_lt};
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL directed[%0d] a=%h b=%h un=%b got={eq,lt}=%b want=%b", i, a, b, br_un, got, want);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] got, want;
        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            b = (i % 7 == 0) ? a : (i % 11 == 0) ? (a ^ 32'h80000000) : $urandom;
            br_un = i[0];
            exp_q.push_back(golden(a, b, br_un));
            #1;
            got = {c_eq, c_lt};
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want || got == 2'b11) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h un=%b got={eq,lt}=%b want=%b", i, a, b, br_un, got, want);
            end
        end
    endtask

    task automatic test_registered();
        logic [1:0] got, want;
        @(negedge clk);
        a = 32'd3;
        b = 32'd3;
        br_un = 1'b0;
        rst = 1'b0;
        exp_q.push_back(2'b10);
        #1;
        got = {r_eq, r_lt};
        n_cmp++;
        if (got !== 2'b00) begin
            n_err++;
            $display("FAIL release_hold got=%b want=00", got);
        end
        @(posedge clk);
        #1;
        got = {r_eq, r_lt};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL first_load got=%b want=%b", got, want);
        end
        @(negedge clk);
        a = 32'd1;
        b = 32'd2;
        exp_q.push_back(2'b01);
        #1;
        got = {r_eq, r_lt};
        n_cmp++;
        if (got !== 2'b10) begin
            n_err++;
            $display("FAIL latency_early got=%b want=10", got);
        end
        @(posedge clk);
        #1;
        got = {r_eq, r_lt};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL latency_one got=%b want=%b", got, want);
        end
        a = 32'd9;
        b = 32'd5;
        #2;
        a = 32'd7;
        b = 32'd7;
        #1;
        got = {r_eq, r_lt};
        n_cmp++;
        if (got !== 2'b01) begin
            n_err++;
            $display("FAIL between_edges got=%b want=01", got);
        end
        a = 32'hFFFFFFFF;
        b = 32'd1;
        br_un = 1'b1;
        exp_q.push_back(2'b00);
        @(posedge clk);
        #1;
        got = {r_eq, r_lt};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL last_value_wins got=%b want=%b", got, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] got, want;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            a = (i % 5 == 0) ? 32'h80000000 : $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            br_un = i[1];
            exp_q.push_back(golden(a, b, br_un));
            @(posedge clk);
            #1;
            got = {r_eq, r_lt};
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [1:0] got, want;
        @(negedge clk);
        a = 32'd1;
        b = 32'd2;
        br_un = 1'b0;
        exp_q.push_back(2'b01);
        @(posedge clk);
        #1;
        got = {r_eq, r_lt};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL pre_rst_load got=%b want=%b", got, want);
        end
        a = 32'd4;
        b = 32'd4;
        #1;
        rst = 1'b1;
        #1;
        got = {r_eq, r_lt};
        n_cmp++;
        if (got !== 2'b00) begin
            n_err++;
            $display("FAIL async_clear got=%b want=00", got);
        end
        @(posedge clk);
        #1;
        got = {r_eq, r_lt};
        n_cmp++;
        if (got !== 2'b00) begin
            n_err++;
            $display("FAIL rst_hold got=%b want=00", got);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        a = 32'd1;
        b = 32'd2;
        exp_q.push_back(2'b01);
        @(posedge clk);
        #1;
        got = {r_eq, r_lt};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL post_rst_load got=%b want=%b", got, want);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_registered();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
